// File: rtl/alu_op_issuer.sv
// Request FIFO and registered response stage in front of the combinational ALU.
// Illegal opcodes still reach the ALU; only the captured response is zeroed and flagged.
module alu_op_issuer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic [3:0]               in_opcode,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [3:0]               alu_opcode,
    input  logic [WIDTH-1:0]         alu_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [3:0]               out_opcode,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_GT  = 4'd2;
    localparam logic [3:0] OP_LE  = 4'd4;

    logic [WIDTH-1:0] mem_a  [DEPTH];
    logic [WIDTH-1:0] mem_b  [DEPTH];
    logic [3:0]       mem_op [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] occ;

    logic push;
    logic issue;
    logic empty;
    logic head_legal;

    assign empty    = (occ == '0);
    assign in_ready = (occ < FULL);
    assign push     = in_valid && in_ready;
    assign issue    = !empty && (!out_valid || out_ready);
    assign count    = occ;

    // Head is presented unmodified, zeroed only when nothing is queued.
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = '0;
        if (!empty) begin
            alu_a      = mem_a[rd_ptr];
            alu_b      = mem_b[rd_ptr];
            alu_opcode = mem_op[rd_ptr];
        end
    end

    always_comb begin
        head_legal = 1'b0;
        case (alu_opcode)
            OP_ADD:  head_legal = 1'b1;
            OP_SUB:  head_legal = 1'b1;
            OP_GT:   head_legal = 1'b1;
            OP_LE:   head_legal = 1'b1;
            default: head_legal = 1'b0;
        endcase
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= in_a;
            mem_b[wr_ptr]  <= in_b;
            mem_op[wr_ptr] <= in_opcode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, issue})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_opcode <= '0;
            out_err    <= 1'b0;
        end else if (issue) begin
            out_valid  <= 1'b1;
            out_result <= head_legal ? alu_result : '0;
            out_opcode <= alu_opcode;
            out_err    <= !head_legal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
